// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, RAM handshake state, arbiter state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_INSTR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_perf.sv
// rtl/mem_arbiter_perf.sv - hit and stall counters for the memory arbiter (MEM_ARBITER_PERF_EN)
module mem_arbiter_perf
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  nRST,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  stall,
  output word_t icount,
  output word_t dcount,
  output word_t stallcount
);

  word_t icount_q, icount_d;
  word_t dcount_q, dcount_d;
  word_t stall_q, stall_d;

  // Free-running counters, wrapping modulo 2^32
  always_comb begin
    icount_d = icount_q + {31'd0, ihit};
    dcount_d = dcount_q + {31'd0, dhit};
    stall_d  = stall_q + {31'd0, stall};
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
      stall_q  <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
      stall_q  <= stall_d;
    end
  end

  assign icount     = icount_q;
  assign dcount     = dcount_q;
  assign stallcount = stall_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter for fetch/data with fairness and watchdog (MEM_ARBITER_PERF_EN)
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      nRST,
  input  logic      imemREN,
  input  word_t     imemaddr,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     imemload,
  output word_t     dmemload,
  output logic      memerr,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
`ifdef MEM_ARBITER_PERF_EN
  ,
  output word_t     icount,
  output word_t     dcount,
  output word_t     stallcount
`endif
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = ARB_IDLE;
  localparam logic [1:0] DATA  = ARB_DATA;
  localparam logic [1:0] INSTR = ARB_INSTR;

  logic [1:0]    state_q, state_d;
  logic          last_data_q, last_data_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          req_live;

  // Whether the requester currently holding the grant still wants it
  assign req_live = (state_q == DATA)  ? (dmemREN | dmemWEN) :
                    (state_q == INSTR) ? imemREN : 1'b0;

  // Grant selection, RAM strobes, completion and watchdog abort
  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    wait_d      = '0;
    ihit        = 1'b0;
    dhit        = 1'b0;
    imemload    = '0;
    dmemload    = '0;
    memerr      = 1'b0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IDLE: begin
        // Data wins unless the last completion was data and fetch is waiting
        if ((dmemREN | dmemWEN) && !(imemREN && last_data_q)) state_d = DATA;
        else if (imemREN)                                    state_d = INSTR;
      end
      DATA, INSTR: begin
        if (!req_live) begin
          state_d = IDLE;
        end else begin
          if (state_q == DATA) begin
            ramREN   = dmemREN;
            ramWEN   = dmemWEN;
            ramaddr  = dmemaddr;
            ramstore = dmemstore;
          end else begin
            ramREN   = 1'b1;
            ramaddr  = imemaddr;
          end
          if (ramstate == ACCESS) begin
            state_d = IDLE;
            if (state_q == DATA) begin
              dhit        = 1'b1;
              dmemload    = ramload;
              last_data_d = 1'b1;
            end else begin
              ihit        = 1'b1;
              imemload    = ramload;
              last_data_d = 1'b0;
            end
          end else if (ramstate == ERROR || wait_q == WAIT_LAST) begin
            memerr  = 1'b1;
            state_d = IDLE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      wait_q      <= wait_d;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  logic stall;
  assign stall = req_live && (ramstate != ACCESS);

  mem_arbiter_perf u_perf (
    .clk        (clk),
    .nRST       (nRST),
    .ihit       (ihit),
    .dhit       (dhit),
    .stall      (stall),
    .icount     (icount),
    .dcount     (dcount),
    .stallcount (stallcount)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 64;

  logic      clk = 1'b0;
  logic      nRST;
  logic      imemREN, dmemREN, dmemWEN;
  word_t     imemaddr, dmemaddr, dmemstore, ramload;
  ramstate_t ramstate;
  logic      ihit, dhit, memerr, ramREN, ramWEN;
  word_t     imemload, dmemload, ramaddr, ramstore;
`ifdef MEM_ARBITER_PERF_EN
  word_t     icount, dcount, stallcount;
`endif

  int total = 0;
  int bad   = 0;

  // Model: who holds the RAM (0 none, 1 data, 2 instr), cycles waited, fairness bit
  int          m_owner = 0;
  int          m_wait  = 0;
  bit          m_last  = 1'b0;
  logic [31:0] m_ic = '0, m_dc = '0, m_sc = '0;

  // Values observed at the most recent tick
  logic        o_ihit, o_dhit, o_memerr, o_ren, o_wen;
  logic [31:0] o_sc;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .ihit      (ihit),
    .dhit      (dhit),
    .imemload  (imemload),
    .dmemload  (dmemload),
    .memerr    (memerr),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate)
`ifdef MEM_ARBITER_PERF_EN
    ,
    .icount    (icount),
    .dcount    (dcount),
    .stallcount(stallcount)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance one clock
  task automatic tick();
    logic e_ih, e_dh, e_me, e_ren, e_wen, live, st;
    logic [31:0] e_il, e_dl, e_addr, e_st;
    int nxt;
    #3;
    e_ih = 0; e_dh = 0; e_me = 0; e_ren = 0; e_wen = 0; st = 0;
    e_il = 0; e_dl = 0; e_addr = 0; e_st = 0;
    nxt = m_owner;
    if (m_owner == 0) begin
      if ((dmemREN || dmemWEN) && !(imemREN && m_last)) nxt = 1;
      else if (imemREN) nxt = 2;
    end else begin
      live = (m_owner == 1) ? (dmemREN || dmemWEN) : imemREN;
      if (!live) nxt = 0;
      else begin
        if (m_owner == 1) begin
          e_ren = dmemREN; e_wen = dmemWEN; e_addr = dmemaddr; e_st = dmemstore;
        end else begin
          e_ren = 1; e_addr = imemaddr;
        end
        if (ramstate == ACCESS) begin
          nxt = 0;
          if (m_owner == 1) begin e_dh = 1; e_dl = ramload; end
          else begin e_ih = 1; e_il = ramload; end
        end else begin
          st = 1;
          if (ramstate == ERROR || m_wait == TIMEOUT - 1) begin
            e_me = 1; nxt = 0;
          end
        end
      end
    end
    chk("ihit", {31'd0, ihit}, {31'd0, e_ih});
    chk("dhit", {31'd0, dhit}, {31'd0, e_dh});
    chk("memerr", {31'd0, memerr}, {31'd0, e_me});
    chk("ramREN", {31'd0, ramREN}, {31'd0, e_ren});
    chk("ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_st);
    chk("imemload", imemload, e_il);
    chk("dmemload", dmemload, e_dl);
`ifdef MEM_ARBITER_PERF_EN
    chk("icount", icount, m_ic);
    chk("dcount", dcount, m_dc);
    chk("stallcount", stallcount, m_sc);
    o_sc = stallcount;
`else
    o_sc = '0;
`endif
    o_ihit = ihit; o_dhit = dhit; o_memerr = memerr; o_ren = ramREN; o_wen = ramWEN;
    if (nRST) begin
      m_owner = 0; m_wait = 0; m_last = 0; m_ic = 0; m_dc = 0; m_sc = 0;
    end else begin
      if (e_dh) m_last = 1;
      if (e_ih) m_last = 0;
      m_wait  = (nxt == m_owner && m_owner != 0) ? m_wait + 1 : 0;
      m_owner = nxt;
      m_ic = m_ic + 32'(e_ih);
      m_dc = m_dc + 32'(e_dh);
      m_sc = m_sc + 32'(st);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev_hit, viol, n_err;
    logic [31:0] sc_a;

    // Reset held with a pending fetch and a busy RAM
    nRST = 1; imemREN = 1; imemaddr = 32'h0000_0040;
    dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0;
    ramload = 0; ramstate = BUSY;
    @(posedge clk); @(posedge clk); #1;
    tick();
    chk("reset_ramREN", {31'd0, o_ren}, 32'd0);

    // Release: fetch granted, two BUSY cycles then ACCESS
    nRST = 0;
    tick();
    tick();
    chk("instr_grant_ren", {31'd0, o_ren}, 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'h8C01_0004;
    tick();
    chk("instr_ihit", {31'd0, o_ihit}, 32'd1);

    // Both pending after a fetch completion: data first, then fetch
    dmemWEN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("data_first_dhit", {31'd0, o_dhit}, 32'd1);
    chk("data_first_wen", {31'd0, o_wen}, 32'd1);
    tick();
    tick();
    chk("then_instr_ihit", {31'd0, o_ihit}, 32'd1);

    // Continuous data reads and fetches: completions must alternate
    dmemWEN = 0; dmemREN = 1;
    prev_hit = 2; viol = 0;
    for (int i = 0; i < 60; i++) begin
      ramstate = ($urandom_range(0, 1) != 0) ? ACCESS : BUSY;
      ramload = $urandom; imemaddr = $urandom; dmemaddr = $urandom;
      tick();
      if (o_dhit) begin if (prev_hit == 1) viol++; prev_hit = 1; end
      if (o_ihit) begin if (prev_hit == 2) viol++; prev_hit = 2; end
    end
    chk("alternation", 32'(viol), 32'd0);

    // Drain, then watchdog: RAM stuck BUSY on a data read
    dmemREN = 0; imemREN = 0; ramstate = BUSY;
    tick(); tick();
    dmemREN = 1;
    tick();
    n_err = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (o_memerr) begin n_err = n; break; end
    end
    chk("watchdog_cycles", 32'(n_err), 32'(TIMEOUT));
    chk("watchdog_no_hit", {31'd0, o_dhit}, 32'd0);

    // Data read withdrawn two cycles into the grant
    dmemREN = 0;
    tick(); tick();
    dmemREN = 1;
    tick();
    sc_a = o_sc;
    tick(); tick();
    dmemREN = 0;
    tick();
    chk("withdraw_ren", {31'd0, o_ren}, 32'd0);
    chk("withdraw_dhit", {31'd0, o_dhit}, 32'd0);
    tick();
`ifdef MEM_ARBITER_PERF_EN
    chk("withdraw_stall", o_sc - sc_a, 32'd2);
`endif

    // Randomised traffic, including errors, withdrawals and occasional reset
    for (int i = 0; i < 3000; i++) begin
      int k;
      imemREN = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 2);
      dmemREN = (k == 1); dmemWEN = (k == 2);
      imemaddr = $urandom; dmemaddr = $urandom; dmemstore = $urandom; ramload = $urandom;
      k = $urandom_range(0, 19);
      ramstate = (k == 0) ? ERROR : (k < 7) ? ACCESS : (k < 9) ? FREE : BUSY;
      nRST = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter directly downstream of the request unit: it takes the instruction-fetch request (imemREN) and the registered data request (dmemREN/dmemWEN), grants one at a time to the shared RAM port, and returns ihit/dhit plus load data to the datapath and request unit. Data accesses win by default; round-robin fairness prevents fetch starvation; a watchdog aborts RAM transactions that never complete.

## Interface
- TIMEOUT, 64: cycles a granted transaction may wait for ACCESS before abort (≥2).
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, all state on rising edge
- nRST  in  1  synchronous reset, active-high (asserted = 1 despite the name)
- imemREN  in  1  instruction read request
- imemaddr  in  32  instruction address
- dmemREN  in  1  data read request
- dmemWEN  in  1  data write request (never asserted together with dmemREN)
- dmemaddr  in  32  data address
- dmemstore  in  32  write data
- ihit  out  1  instruction access completed this cycle
- dhit  out  1  data access completed this cycle
- imemload  out  32  fetched instruction, valid when ihit
- dmemload  out  32  read data, valid when dhit
- memerr  out  1  one-cycle pulse on watchdog abort or RAM ERROR
- ramREN, ramWEN  out  1  RAM strobes
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

## Operation
- FSM states: IDLE, DATA, INSTR.
- IDLE: no RAM strobes. Next: DATA if (dmemREN|dmemWEN) and not (imemREN and last_data); else INSTR if imemREN; else IDLE.
- last_data: 1-bit register, set on dhit, cleared on ihit; gives instruction the grant when both pending and the previous completion was data.
- DATA: ramREN=dmemREN, ramWEN=dmemWEN, ramaddr=dmemaddr, ramstore=dmemstore. ramstate==ACCESS → dhit=1, dmemload=ramload, next IDLE.
- INSTR: ramREN=1, ramWEN=0, ramaddr=imemaddr. ramstate==ACCESS → ihit=1, imemload=ramload, next IDLE.
- Request withdrawn mid-grant (DATA with dmemREN=dmemWEN=0, or INSTR with imemREN=0): strobes drop in that cycle, no hit, next IDLE.
- ramstate==ERROR in DATA/INSTR: no hit, memerr=1, next IDLE; requester retries.
- Watchdog: wait counter cleared on entry to DATA/INSTR, increments each cycle without ACCESS; at TIMEOUT-1 → memerr=1, next IDLE, no hit.
- ihit and dhit are never asserted together.
- Counter width $clog2(TIMEOUT)+1; no wrap reachable.

## Timing
- Reset (nRST=1 at clock edge): state=IDLE, last_data=0, counter=0; ihit=dhit=memerr=0, ramREN=ramWEN=0, ramaddr/ramstore/imemload/dmemload=0 the following cycle.
- Reset mid-transaction: aborted at the edge, no hit, no memerr.
- ihit/dhit/loads/memerr are combinational from state and ramstate: asserted in the same cycle RAM reports ACCESS.
- Minimum latency: request seen in IDLE at cycle N, grant state at N+1, hit at N+1 if ramstate==ACCESS that cycle. Back-to-back accesses: one IDLE cycle between grants.
- Request unit drops dmemREN/dmemWEN one cycle after dhit; arbiter is already in IDLE, so no duplicate access.

## Configuration
- MEM_ARBITER_PERF_EN defined: adds outputs icount, dcount, stallcount (32 each): ihits, dhits, and cycles in DATA/INSTR without ACCESS; zeroed on reset, wrap modulo 2^32.
- Not defined: ports and counters absent; arbitration behaviour identical.

## Structure
- cpu_types_pkg: word_t, ramstate_t (existing), plus arb_state_t enum (IDLE, DATA, INSTR).
- Sub-module mem_arbiter_perf holds the three counters, instantiated only under MEM_ARBITER_PERF_EN.

## Test plan
- Reset with imemREN=1, ramstate=BUSY → all outputs 0; after release INSTR granted, ramREN=1, ramaddr=imemaddr.
- imemREN=1 imemaddr=0x0000_0040, ramstate ACCESS after 2 BUSY cycles, ramload=0x8C01_0004 → ihit one cycle, imemload=0x8C01_0004.
- imemREN and dmemWEN both high, dmemaddr=0x100, dmemstore=0xDEAD_BEEF, last_data=0 → DATA first, ramWEN=1, dhit; next grant INSTR, ihit.
- Continuous dmemREN and imemREN → grants alternate DATA/INSTR, ihit never more than one grant apart.
- ramstate stuck BUSY, TIMEOUT=64 → memerr pulse exactly 64 cycles after grant, no hit, state IDLE.
- dmemREN dropped two cycles into DATA → ramREN=0 that cycle, no dhit, IDLE next; with MEM_ARBITER_PERF_EN stallcount=2.
